rca_multiword_seq: RTL and testbench
====================================

Name: rca_multiword_seq

Overview:
- Sequencer that performs a WIDTH-bit addition by time-multiplexing one external SLICE-bit ripple-carry adder slice.
- Least-significant slice is processed first; the carry is registered between cycles.
- Sits between a requester (start/done handshake) and the team's existing 4-bit ripple-carry adder, which is instantiated alongside it and wired to the slice_* ports.

Parameters:
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, width of the external adder slice.
- NSLICE (localparam), WIDTH/SLICE, number of slice steps per operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  request pulse; sampled on rising clk when not busy.
- A  in  WIDTH  operand A; captured on accepted start.
- B  in  WIDTH  operand B; captured on accepted start.
- Cin  in  1  carry-in; captured on accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when SUM/CARRY/OVF are final.
- SUM  out  WIDTH  registered result.
- CARRY  out  1  registered carry-out of the MSB slice.
- OVF  out  1  registered signed overflow.
- slice_a  out  SLICE  operand A slice to external adder.
- slice_b  out  SLICE  operand B slice to external adder.
- slice_cin  out  1  carry-in to external adder.
- slice_sum  in  SLICE  sum from external adder (combinational, same cycle).
- slice_cout  in  1  carry-out from external adder (combinational, same cycle).

Behaviour:
- Reset (rst_n low, asynchronous):
  - Outputs: state=IDLE, busy=0, done=0, SUM=0, CARRY=0, OVF=0, slice_a=0, slice_b=0, slice_cin=0.
  - Internal: idx=0, carry_reg=0, operand regs cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 → capture A, B, Cin; carry_reg←Cin; idx←0; go RUN.
  - Otherwise stay in IDLE.
- RUN (busy=1):
  - slice_a = A_reg[idx*SLICE +: SLICE], slice_b = B_reg[idx*SLICE +: SLICE], slice_cin = carry_reg.
  - Each edge: SUM[idx*SLICE +: SLICE] ← slice_sum; carry_reg ← slice_cout; idx ← idx+1.
  - On the edge where idx==NSLICE-1:
    - CARRY ← slice_cout.
    - OVF ← (A_reg[WIDTH-1]==B_reg[WIDTH-1]) && (slice_sum[SLICE-1]!=A_reg[WIDTH-1]).
    - Go DONE.
- DONE:
  - done=1 for exactly this cycle, busy=0.
  - start=1 in this cycle is accepted (same capture as IDLE) → RUN; otherwise → IDLE.
- Slice drive outside RUN: slice_a/slice_b/slice_cin forced to 0 in IDLE and DONE.
- Latency: start sampled at edge 0 → RUN occupies edges 1..NSLICE → done high between edges NSLICE and NSLICE+1 (4 cycles at defaults).
  - Back-to-back throughput: one result every NSLICE+1 cycles.
- start while busy=1 is ignored: no capture, operation continues unaffected.
- SUM/CARRY/OVF hold their last final values until the next operation writes them.
  - SUM is updated slice-by-slice during RUN, so it is valid only when done=1 or afterwards until the next accepted start.
- A/B/Cin may change freely after the accepted start; only the captured copies are used.
- Reset mid-RUN: immediate return to IDLE with all reset values; the partial result is discarded; no done pulse.
- Arithmetic is unsigned modulo 2^WIDTH; CARRY is the true carry-out; OVF is two's-complement overflow.

Test Plan:
- Bench wiring: the existing 4-bit ripple-carry adder as the slice; WIDTH=16.
- Carry across a slice boundary: A=0x00FF, B=0x0001, Cin=0, start pulse → done exactly 4 cycles later; SUM=0x0100, CARRY=0, OVF=0.
  - During RUN, slice_cin sequence is 0,1,1,0.
- Full ripple with carry-in: A=0xFFFF, B=0x0000, Cin=1 → SUM=0x0000, CARRY=1, OVF=0.
  - busy high for exactly 4 cycles.
- Signed overflow: A=0x7FFF, B=0x0001, Cin=0 → SUM=0x8000, CARRY=0, OVF=1.
  - Also A=0x8000, B=0x8000 → SUM=0x0000, CARRY=1, OVF=1.
- Start ignored while busy: start A=0x1234, B=0x1111; pulse start again at RUN cycle 2 with A=0xFFFF → result SUM=0x2345, single done pulse, no second operation.
- Back-to-back start in the DONE cycle: start in the DONE cycle with A=0x0D0D, B=0x0D0D, Cin=1 → second done 5 cycles after the first, SUM=0x1A1B.
- Reset mid-operation: deassert rst_n in RUN cycle 2 → outputs zero immediately (asynchronously), no done pulse.
  - After release, a fresh start with A=0x0003, B=0x0003 gives SUM=0x0006.

Source files
------------

// File: rtl/rca_multiword_seq.sv
// Multi-word adder sequencer. It adds two WIDTH-bit operands using one external
// SLICE-bit ripple-carry adder slice, one slice per clock cycle. The least
// significant slice goes first, and the carry is held in a register between slices.
// WIDTH must be an integer multiple of SLICE.
module rca_multiword_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] SUM,
  output logic             CARRY,
  output logic             OVF,
  output logic [SLICE-1:0] slice_a,
  output logic [SLICE-1:0] slice_b,
  output logic             slice_cin,
  input  logic [SLICE-1:0] slice_sum,
  input  logic             slice_cout
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic             carry_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;

  // Present the current slice to the external adder only while running.
  // Outside RUN the slice lines are held at zero.
  always_comb begin
    slice_a   = '0;
    slice_b   = '0;
    slice_cin = 1'b0;
    if (state == RUN) begin
      slice_a   = a_reg[int'(idx)*SLICE +: SLICE];
      slice_b   = b_reg[int'(idx)*SLICE +: SLICE];
      slice_cin = carry_reg;
    end
  end

  // Sequencer FSM. busy and done are registered, and they change on the same
  // edges as the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      SUM       <= '0;
      CARRY     <= 1'b0;
      OVF       <= 1'b0;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Cin;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          SUM[int'(idx)*SLICE +: SLICE] <= slice_sum;
          carry_reg <= slice_cout;
          idx       <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            CARRY <= slice_cout;
            // Signed overflow: both operands have the same sign, but the result has the other sign.
            OVF   <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                     (slice_sum[SLICE-1] != a_reg[WIDTH-1]);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          // A start in the DONE cycle is accepted, which allows back-to-back operations.
          if (start) begin
            a_reg     <= A;
            b_reg     <= B;
            carry_reg <= Cin;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rca_multiword_seq.sv
// Testbench for rca_multiword_seq with WIDTH=16 and a 4-bit ripple-carry slice.
// A scoreboard queue holds the expected results, which are popped and compared on each done pulse.
module tb_rca_multiword_seq;

  localparam int W = 16;
  localparam int S = 4;

  logic         clk, rst_n, start, Cin;
  logic [W-1:0] A, B;
  logic         busy, done, CARRY, OVF;
  logic [W-1:0] SUM;
  logic [S-1:0] slice_a, slice_b, slice_sum;
  logic         slice_cin, slice_cout;

  rca_multiword_seq #(.WIDTH(W), .SLICE(S)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B), .Cin(Cin),
    .busy(busy), .done(done), .SUM(SUM), .CARRY(CARRY), .OVF(OVF),
    .slice_a(slice_a), .slice_b(slice_b), .slice_cin(slice_cin),
    .slice_sum(slice_sum), .slice_cout(slice_cout)
  );

  // 4-bit ripple-carry slice built from full adders
  always_comb begin
    logic c;
    c = slice_cin;
    slice_sum = '0;
    for (int i = 0; i < S; i++) begin
      slice_sum[i] = slice_a[i] ^ slice_b[i] ^ c;
      c = (slice_a[i] & slice_b[i]) | (c & (slice_a[i] ^ slice_b[i]));
    end
    slice_cout = c;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;
  int   busy_cnt = 0;
  int   done_cnt = 0;
  logic [3:0] cin_log = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    exp_t e;
    logic [W:0] t;
    t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    e.sum   = t[W-1:0];
    e.carry = t[W];
    e.ovf   = (a[W-1] == b[W-1]) && (t[W-1] != a[W-1]);
    return e;
  endfunction

  // Monitor: sample away from the active edge, log slice carries, and score results.
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      cin_log = {cin_log[2:0], slice_cin};
      busy_cnt++;
    end
    if (done) begin
      done_cnt++;
      if (sb.size() == 0) chk("spurious_done", {31'd0, done}, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sum",   {16'd0, SUM},  {16'd0, e.sum});
        chk("carry", {31'd0, CARRY}, {31'd0, e.carry});
        chk("ovf",   {31'd0, OVF},   {31'd0, e.ovf});
      end
    end
  end

  // Drive operands and a single-cycle start pulse. Returns at edge0 + #1.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input exp_t e);
    A = a; B = b; Cin = cin; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Count the posedges until done is seen at #1 after an edge. The wait is bounded.
  task automatic wait_done(output int n);
    bit seen;
    seen = 0; n = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (done) begin seen = 1; n = i; end
    end
    if (!seen) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic idle_cycle();
    @(posedge clk); #1;
  endtask

  vec_t vt[$];
  int   n, d0;
  exp_t e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt.push_back('{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0});
    vt.push_back('{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0});
    vt.push_back('{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1});
    vt.push_back('{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1});
    vt.push_back('{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0});
    vt.push_back('{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1});
    vt.push_back('{16'hA5A5, 16'h5A5A, 1'b0, 16'hFFFF, 1'b0, 1'b0});
    vt.push_back('{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0});

    rst_n = 1'b1; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_sum",   {16'd0, SUM},  32'd0);
    chk("rst_flags", {30'd0, CARRY, OVF}, 32'd0);
    chk("rst_slice", {23'd0, slice_a, slice_b, slice_cin}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle_cycle();

    // Table-driven vectors: check latency, busy length, and the result via the scoreboard.
    foreach (vt[i]) begin
      busy_cnt = 0;
      launch(vt[i].a, vt[i].b, vt[i].cin, '{vt[i].sum, vt[i].carry, vt[i].ovf});
      wait_done(n);
      chk("latency", n, 4);
      chk("busy_cycles", busy_cnt, 4);
      if (i == 0) chk("slice_cin_seq", {28'd0, cin_log}, 32'b0110);
      idle_cycle();
    end

    // Random vectors, with expected values from the arithmetic model.
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb;
      logic rc;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom_range(1));
      launch(ra, rb, rc, model(ra, rb, rc));
      wait_done(n);
      chk("rand_latency", n, 4);
      idle_cycle();
    end

    // Back-to-back operation: a start in the DONE cycle is accepted.
    launch(16'h0101, 16'h0202, 1'b0, '{16'h0303, 1'b0, 1'b0});
    wait_done(n);
    A = 16'h0D0D; B = 16'h0D0D; Cin = 1'b1; start = 1'b1;
    sb.push_back('{16'h1A1B, 1'b0, 1'b0});
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(n);
    chk("b2b_gap", n + 1, 5);
    idle_cycle();

    // A start while busy is ignored.
    d0 = done_cnt;
    launch(16'h1234, 16'h1111, 1'b0, '{16'h2345, 1'b0, 1'b0});
    idle_cycle();
    A = 16'hFFFF; start = 1'b1;
    idle_cycle();
    start = 1'b0;
    wait_done(n);
    chk("ignore_latency", n, 2);
    repeat (8) idle_cycle();
    chk("ignore_done_count", done_cnt - d0, 1);
    chk("ignore_sb_empty", sb.size(), 0);

    // Reset during RUN: outputs clear asynchronously and no done pulse follows.
    d0 = done_cnt;
    launch(16'h5555, 16'h2222, 1'b0, '{16'h7777, 1'b0, 1'b0});
    idle_cycle();
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("mid_rst_busy",  {31'd0, busy}, 32'd0);
    chk("mid_rst_sum",   {16'd0, SUM},  32'd0);
    chk("mid_rst_slice", {23'd0, slice_a, slice_b, slice_cin}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (6) idle_cycle();
    chk("mid_rst_no_done", done_cnt - d0, 0);
    launch(16'h0003, 16'h0003, 1'b0, '{16'h0006, 1'b0, 1'b0});
    wait_done(n);
    chk("post_rst_latency", n, 4);
    idle_cycle();
    chk("final_sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
